// File: rtl/wb_lcd_seq.sv
// -----------------------------------------------------------------------------
// wb_lcd_seq
//   Wishbone slave that queues character and command bytes for an HD44780
//   character LCD and plays them out onto the LCD bus with setup, enable
//   pulse, hold and execution delays. The CPU can write bytes back-to-back
//   without knowing anything about LCD timing; intr is raised when the queue
//   has drained and the sequencer is idle.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   wb_stb_i, wb_cyc_i   Wishbone strobe / cycle
//   wb_we_i              Wishbone write enable
//   wb_adr_i [31:0]      byte address, [3:2] selects DATA/CMD/STATUS/unused
//   wb_sel_i [3:0]       byte selects, only [0] matters
//   wb_dat_i [31:0]      write data, only [7:0] matters
//   wb_dat_o [31:0]      read data, valid in the ack cycle
//   wb_ack_o             single-cycle acknowledge
//   lcd_e, lcd_rs, lcd_rw, lcd_db[7:0]   LCD bus (lcd_rw tied low)
//   intr                 level interrupt: FIFO empty and sequencer idle
// -----------------------------------------------------------------------------
module wb_lcd_seq #(
  parameter int clk_freq   = 50000000,
  parameter int fifo_aw    = 4,
  parameter int t_setup    = 2,
  parameter int t_pulse    = 12,
  parameter int t_hold     = 1,
  parameter int t_exec_us  = 40,
  parameter int t_clear_us = 1640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_db,
  output logic        intr
);

  localparam int depth         = 1 << fifo_aw;
  localparam int cycles_per_us = clk_freq / 1000000;
  localparam int exec_raw      = cycles_per_us * t_exec_us;
  localparam int clear_raw     = cycles_per_us * t_clear_us;
  // A zero count would make the down-counter wrap, so every phase lasts
  // at least one cycle.
  localparam int exec_cyc      = (exec_raw  < 1) ? 1 : exec_raw;
  localparam int clear_cyc     = (clear_raw < 1) ? 1 : clear_raw;
  localparam int setup_cyc     = (t_setup   < 1) ? 1 : t_setup;
  localparam int pulse_cyc     = (t_pulse   < 1) ? 1 : t_pulse;
  localparam int hold_cyc      = (t_hold    < 1) ? 1 : t_hold;
  localparam int max_a         = (clear_cyc > exec_cyc)  ? clear_cyc : exec_cyc;
  localparam int max_b         = (setup_cyc > pulse_cyc) ? setup_cyc : pulse_cyc;
  localparam int max_c         = (max_b > hold_cyc)      ? max_b     : hold_cyc;
  localparam int cnt_max       = (max_a > max_c)         ? max_a     : max_c;
  localparam int cnt_w         = $clog2(cnt_max + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t             state;
  logic [cnt_w-1:0]   cnt;

  logic [8:0]         mem [depth];
  logic [fifo_aw-1:0] wr_ptr;
  logic [fifo_aw-1:0] rd_ptr;
  logic [fifo_aw:0]   level;
  logic               overflow;

  logic [1:0]         reg_sel;
  logic               req;
  logic               push;
  logic               push_ok;
  logic               pop;
  logic               full;
  logic               stat_rd;
  logic               is_clear;
  logic [8:0]         head;
  logic [31:0]        rdata;

  logic               unused_inputs;
  assign unused_inputs = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:8]};

  // ---------------------------------------------------------------------------
  // Bus decode. The ~wb_ack_o term blocks a second acceptance while the
  // master still holds stb during the ack cycle.
  // ---------------------------------------------------------------------------
  assign reg_sel = wb_adr_i[3:2];
  assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign push    = req & wb_we_i & wb_sel_i[0] & ~reg_sel[1];
  assign full    = (level == (fifo_aw+1)'(depth));
  assign push_ok = push & ~full;
  assign stat_rd = req & ~wb_we_i & (reg_sel == 2'b10);
  assign pop     = (state == IDLE) && (level != '0);
  assign head    = mem[rd_ptr];
  assign intr    = (state == IDLE) && (level == '0);
  assign lcd_rw  = 1'b0;

  // Clear/home commands need the long execution wait.
  assign is_clear = ~lcd_rs && ((lcd_db == 8'h01) || (lcd_db == 8'h02) || (lcd_db == 8'h03));

  always_comb begin
    rdata = '0;
    if (reg_sel == 2'b10) begin
      rdata[0]             = ~intr;
      rdata[1]             = full;
      rdata[2]             = overflow;
      rdata[fifo_aw+4:4]   = level;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      overflow <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rdata : '0;
      // A dropped byte wins over a clearing read; they cannot share an edge
      // anyway since only one request is accepted per ack.
      if (push & full)
        overflow <= 1'b1;
      else if (stat_rd)
        overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: small enough for distributed RAM, read asynchronously so the
  // sequencer can latch the head entry on the same edge it pops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {~reg_sel[0], wb_dat_i[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: one down-counter shared by all timed phases; each phase ends
  // on the edge where the counter reads 1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= '0;
    end else begin
      case (state)
        IDLE: begin
          lcd_e <= 1'b0;
          if (pop) begin
            lcd_rs <= head[8];
            lcd_db <= head[7:0];
            cnt    <= cnt_w'(setup_cyc);
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == cnt_w'(1)) begin
            lcd_e <= 1'b1;
            cnt   <= cnt_w'(pulse_cyc);
            state <= PULSE;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        PULSE: begin
          if (cnt == cnt_w'(1)) begin
            lcd_e <= 1'b0;
            cnt   <= cnt_w'(hold_cyc);
            state <= HOLD;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        HOLD: begin
          if (cnt == cnt_w'(1)) begin
            cnt   <= is_clear ? cnt_w'(clear_cyc) : cnt_w'(exec_cyc);
            state <= WAIT;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        WAIT: begin
          if (cnt == cnt_w'(1))
            state <= IDLE;
          else
            cnt <= cnt - cnt_w'(1);
        end
        default: begin
          lcd_e <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
